// File: rtl/interrupt_controller.sv
// Four-source priority interrupt controller: lowest index wins; one IDLE->REQ->ACK round per service.
// Latency: raise in IDLE -> CPU_INTERRUPT next clock; CPU ack -> IRQ_ACK pulse next clock.
// Backpressure: request held stable until CPU_INTERRUPT_ACK; optional software trigger via INTC_SW_TRIGGER_EN.
module interrupt_controller #(
    parameter logic [7:0] IntcBaseAddr = 8'hE0,
    parameter logic [3:0] InitialMask  = 4'hF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    input  logic [3:0] IRQ_RAISE,
    output logic [3:0] IRQ_ACK,
    output logic       CPU_INTERRUPT,
    output logic [1:0] CPU_INTERRUPT_ID,
    input  logic       CPU_INTERRUPT_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] id;
    logic [3:0] mask;
    logic [3:0] sw_pend;
    logic [3:0] req_vec;
    logic [1:0] first_id;
    logic [7:0] offset;
    logic       addr_hit;
    logic [1:0] reg_sel;
    logic       rd_drive;
    logic [7:0] rd_data;
    logic       unused_data_hi;

    // Offset arithmetic keeps decode correct even for an unaligned base.
    assign offset         = BUS_ADDR - IntcBaseAddr;
    assign addr_hit       = (offset[7:2] == 6'd0);
    assign reg_sel        = offset[1:0];
    assign unused_data_hi = ^BUS_DATA[7:4];

`ifdef INTC_SW_TRIGGER_EN
    logic [3:0] sw_set;
    logic [3:0] sw_clr;

    assign sw_set = (BUS_WE && addr_hit && reg_sel == 2'd3) ? BUS_DATA[3:0] : 4'b0;
    assign sw_clr = (state == ACK) ? (4'b0001 << id) : 4'b0;

    // Clear first, then set, so a same-cycle trigger on the acked bit survives.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sw_pend <= 4'b0;
        end else begin
            sw_pend <= (sw_pend & ~sw_clr) | sw_set;
        end
    end
`else
    assign sw_pend = 4'b0;
`endif

    assign req_vec = (IRQ_RAISE | sw_pend) & mask;

    always_comb begin
        first_id = 2'd0;
        if (req_vec[0])      first_id = 2'd0;
        else if (req_vec[1]) first_id = 2'd1;
        else if (req_vec[2]) first_id = 2'd2;
        else                 first_id = 2'd3;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            mask <= InitialMask;
        end else if (BUS_WE && addr_hit && reg_sel == 2'd1) begin
            mask <= BUS_DATA[3:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= IDLE;
            id            <= 2'd0;
            CPU_INTERRUPT <= 1'b0;
            IRQ_ACK       <= 4'b0;
        end else begin
            case (state)
                IDLE: begin
                    IRQ_ACK <= 4'b0;
                    if (|req_vec) begin
                        id            <= first_id;
                        CPU_INTERRUPT <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (CPU_INTERRUPT_ACK) begin
                        CPU_INTERRUPT <= 1'b0;
                        IRQ_ACK       <= 4'b0001 << id;
                        state         <= ACK;
                    end
                end
                ACK: begin
                    IRQ_ACK       <= 4'b0;
                    CPU_INTERRUPT <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    IRQ_ACK       <= 4'b0;
                    CPU_INTERRUPT <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign CPU_INTERRUPT_ID = id;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_drive <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            rd_drive <= addr_hit && !BUS_WE;
            case (reg_sel)
                2'd0:    rd_data <= {4'b0, IRQ_RAISE | sw_pend};
                2'd1:    rd_data <= {4'b0, mask};
                2'd2:    rd_data <= {5'b0, (state != IDLE), id};
                default: rd_data <= 8'h00;
            endcase
        end
    end

    assign BUS_DATA = rd_drive ? rd_data : 8'bz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboarded bench for interrupt_controller: directed scenarios followed by randomized mask/raise rounds.
module tb_interrupt_controller;
    localparam logic [7:0] BASE = 8'hE0;
    localparam logic [7:0] IDLE_ADDR = 8'h00;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] BUS_ADDR = IDLE_ADDR;
    wire  [7:0] BUS_DATA;
    logic       BUS_WE = 1'b0;
    logic [3:0] IRQ_RAISE = 4'b0;
    logic [3:0] IRQ_ACK;
    logic       CPU_INTERRUPT;
    logic [1:0] CPU_INTERRUPT_ID;
    logic       CPU_INTERRUPT_ACK = 1'b0;

    logic [7:0] tb_dat = 8'h00;
    logic       tb_oe = 1'b0;
    bit         auto_cpu = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    assign BUS_DATA = tb_oe ? tb_dat : 8'bz;
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup pu (BUS_DATA[g]);
    end

    interrupt_controller #(.IntcBaseAddr(BASE), .InitialMask(4'hF)) dut (
        .CLK(CLK), .RST(RST), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
        .IRQ_RAISE(IRQ_RAISE), .IRQ_ACK(IRQ_ACK), .CPU_INTERRUPT(CPU_INTERRUPT),
        .CPU_INTERRUPT_ID(CPU_INTERRUPT_ID), .CPU_INTERRUPT_ACK(CPU_INTERRUPT_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle; peripherals drop the acknowledged bit, optional random CPU.
    task automatic tick();
        @(negedge CLK);
        if (IRQ_ACK != 4'b0) IRQ_RAISE = IRQ_RAISE & ~IRQ_ACK;
        if (auto_cpu)
            CPU_INTERRUPT_ACK = CPU_INTERRUPT ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        BUS_ADDR = addr; tb_dat = data; tb_oe = 1'b1; BUS_WE = 1'b1;
        tick();
        BUS_WE = 1'b0; tb_oe = 1'b0; BUS_ADDR = IDLE_ADDR;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        BUS_ADDR = addr;
        tick();
        data = BUS_DATA;
        BUS_ADDR = IDLE_ADDR;
        tick();
    endtask

    task automatic serve(input logic [1:0] id, input string nm);
        int n = 0;
        while (!CPU_INTERRUPT && n < 20) begin tick(); n++; end
        check({nm, "_int"}, CPU_INTERRUPT, 1);
        check({nm, "_id"}, CPU_INTERRUPT_ID, id);
        CPU_INTERRUPT_ACK = 1'b1;
        tick();
        CPU_INTERRUPT_ACK = 1'b0;
        check({nm, "_ack"}, IRQ_ACK, 4'b0001 << id);
        tick();
    endtask

    // Monitor: every presentation pops the next expected ID; every ack pulse must match it.
    initial begin
        logic       prev = 1'b0;
        bit         have = 1'b0;
        logic [1:0] cur = 2'd0;
        logic [3:0] expv;
        forever begin
            @(negedge CLK);
            if (CPU_INTERRUPT && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_irq actual_id=%0d expected=none", CPU_INTERRUPT_ID);
                    cur = CPU_INTERRUPT_ID;
                end else begin
                    cur = exp_q.pop_front();
                    check("present_id", CPU_INTERRUPT_ID, cur);
                end
                have = 1'b1;
            end else if (CPU_INTERRUPT && prev) begin
                check("id_stable", CPU_INTERRUPT_ID, cur);
            end
            if (IRQ_ACK != 4'b0) begin
                expv = have ? (4'b0001 << cur) : 4'b0;
                check("ack_vec", IRQ_ACK, expv);
                check("ack_cpu_low", CPU_INTERRUPT, 0);
                have = 1'b0;
            end else if (!CPU_INTERRUPT) begin
                have = 1'b0;
            end
            prev = CPU_INTERRUPT;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [3:0] m, rv, want;
        int n;

        tick(); tick();
        check("rst_int", CPU_INTERRUPT, 0);
        check("rst_ack", IRQ_ACK, 0);
        check("rst_id", CPU_INTERRUPT_ID, 0);
        check("rst_bus_hiz", BUS_DATA, 8'hFF);
        RST = 1'b1;
        tick();
        bus_read(BASE + 8'd1, d); check("rst_mask", d, 8'h0F);
        bus_read(BASE + 8'd2, d); check("rst_active", d, 8'h00);

        // Single source with exact one-clock latencies.
        IRQ_RAISE = 4'b0100; exp_q.push_back(2'd2);
        tick();
        check("single_rise", CPU_INTERRUPT, 1);
        tick();
        check("single_hold", CPU_INTERRUPT, 1);
        CPU_INTERRUPT_ACK = 1'b1;
        tick();
        CPU_INTERRUPT_ACK = 1'b0;
        check("single_ack", IRQ_ACK, 4'b0100);
        check("single_int_low", CPU_INTERRUPT, 0);
        tick();
        check("single_ack_once", IRQ_ACK, 4'b0000);
        tick();

        // CPU ack while idle must do nothing.
        CPU_INTERRUPT_ACK = 1'b1;
        tick(); tick();
        CPU_INTERRUPT_ACK = 1'b0;
        check("idle_ack_ign", IRQ_ACK, 0);
        check("idle_ack_int", CPU_INTERRUPT, 0);

        // Priority: two held sources, lowest first.
        IRQ_RAISE = 4'b1010; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        serve(2'd1, "prio_a");
        serve(2'd3, "prio_b");
        tick();

        // Mask gating and pending readback before masking.
        bus_write(BASE + 8'd1, 8'h0E);
        IRQ_RAISE = 4'b0001;
        tick(); tick(); tick();
        check("mask_block", CPU_INTERRUPT, 0);
        bus_read(BASE + 8'd0, d); check("mask_pending", d, 8'h01);
        exp_q.push_back(2'd0);
        bus_write(BASE + 8'd1, 8'h0F);
        serve(2'd0, "mask_open");
        tick();

        // Read timing in REQ, plus no re-prioritisation on new source / mask change.
        IRQ_RAISE = 4'b1000; exp_q.push_back(2'd3);
        tick();
        check("rd_req", CPU_INTERRUPT, 1);
        BUS_ADDR = BASE + 8'd2;
        tick();
        check("rd_active", BUS_DATA, 8'h07);
        BUS_ADDR = IDLE_ADDR;
        tick();
        check("rd_hiz", BUS_DATA, 8'hFF);
        IRQ_RAISE = IRQ_RAISE | 4'b0001; exp_q.push_back(2'd0);
        bus_write(BASE + 8'd1, 8'h01);
        tick();
        check("hold_int", CPU_INTERRUPT, 1);
        check("hold_id", CPU_INTERRUPT_ID, 3);
        serve(2'd3, "hold");
        serve(2'd0, "late");
        bus_write(BASE + 8'd1, 8'h0F);
        tick();

        // Reset in REQ aborts with no ack pulse and restores the mask.
        bus_write(BASE + 8'd1, 8'h03);
        IRQ_RAISE = 4'b0010; exp_q.push_back(2'd1);
        tick();
        check("rstm_req", CPU_INTERRUPT, 1);
        RST = 1'b0; IRQ_RAISE = 4'b0;
        tick();
        check("rstm_int", CPU_INTERRUPT, 0);
        check("rstm_ack", IRQ_ACK, 0);
        RST = 1'b1;
        tick(); tick();
        check("rstm_noack", IRQ_ACK, 0);
        bus_read(BASE + 8'd1, d); check("rstm_mask", d, 8'h0F);

        // Software trigger.
        bus_write(BASE + 8'd3, 8'h08);
`ifdef INTC_SW_TRIGGER_EN
        exp_q.push_back(2'd3);
        serve(2'd3, "sw");
        tick();
        bus_read(BASE + 8'd0, d); check("sw_pending_clr", d, 8'h00);
`else
        tick(); tick(); tick();
        check("sw_none", CPU_INTERRUPT, 0);
        bus_read(BASE + 8'd0, d); check("sw_pending", d, 8'h00);
`endif
        tick();

        // Randomized rounds: expected order is the set bits of raise&mask, ascending.
        auto_cpu = 1'b1;
        for (int r = 0; r < 40; r++) begin
            m  = 4'($urandom_range(0, 15));
            rv = 4'($urandom_range(1, 15));
            bus_write(BASE + 8'd1, {4'($urandom_range(0, 15)), m});
            want = rv & m;
            for (int i = 0; i < 4; i++)
                if (want[i]) exp_q.push_back(2'(i));
            IRQ_RAISE = rv;
            n = 0;
            while ((IRQ_RAISE & m) != 4'b0 && n < 80) begin tick(); n++; end
            if (n >= 80) begin
                checks++; errors++;
                $display("FAIL rand_drain round=%0d actual_raise=%0h expected=0", r, IRQ_RAISE & m);
            end
            IRQ_RAISE = 4'b0;
            tick(); tick(); tick();
        end
        auto_cpu = 1'b0;
        CPU_INTERRUPT_ACK = 1'b0;
        tick(); tick(); tick();
        check("queue_empty", exp_q.size(), 0);
        check("final_int", CPU_INTERRUPT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
